platform_colour_gen: RTL and testbench

//  Upstream stage of the ball/platform updater. Owns the four platform positions, the four

---
 rtl/platform_colour_gen.sv | 194 +++++++++++++++++++
 tb/tb_platform_colour_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_colour_gen.sv
// platform_colour_gen: upstream stage of the ball/platform updater.
// Owns the platform positions, the platform colours and the ball colour. It scrolls the
// platforms on update cycles and draws a fresh colour set whenever the score changes.
// Optional build macro: DISTINCT_COLOURS_EN makes committed platform colours pairwise distinct.
//
// state  | meaning
// IDLE   | waiting for score_in to differ from the latched score
// GEN    | one LFSR draw per cycle into the next free candidate slot
// PICK   | choose the ball colour from one of the four candidates
// COMMIT | publish all colours at once, held off while statesig == 11
module platform_colour_gen #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned SCROLL_DIV = 8,
   parameter logic [6:0]  PLAT_BASE  = 7'd20,
   parameter logic [6:0]  PLAT_GAP   = 7'd25,
   parameter logic [6:0]  PLAT_WRAP  = 7'd116,
   parameter int unsigned MAX_TRIES  = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  statesig,
   input  logic [31:0] score_in,
   input  logic        gameover,
   output logic [27:0] position_plats,
   output logic [11:0] color_plats,
   output logic [2:0]  color_ball,
   output logic        shuffle_busy,
   output logic        shuffle_done
);

   // A zero seed would lock the LFSR up, so it falls back to the default.
   localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
   localparam logic [15:0] DIV_LAST  = 16'(SCROLL_DIV - 1);
   localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

   typedef enum logic [1:0] {IDLE, GEN, PICK, COMMIT} state_t;

   function automatic logic [2:0] fallback_colour(input int k);
      case (k)
         0:       return 3'b001;
         1:       return 3'b010;
         2:       return 3'b100;
         default: return 3'b111;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [15:0] lfsr_q;
   logic [15:0] scroll_q;
   logic [6:0]  pos_q [4];
   logic [2:0]  col_q [4];
   logic [2:0]  ball_q;
   logic [31:0] score_q, score_d;
   logic        frozen_q;
   logic        freeze;
   logic [2:0]  slot_q [4];
   logic [2:0]  slot_d [4];
   logic [2:0]  fill_q, fill_d;
   logic [7:0]  tries_q, tries_d;
   logic [2:0]  cand_q, cand_d;
   logic [2:0]  draw;
   logic        accept;
   logic        commit;
   logic        busy_q;
   logic        done_q;

   // Gameover freezes the block until the next reset.
   assign freeze = gameover | frozen_q;

   // LFSR free-runs every cycle; platforms scroll one pixel every SCROLL_DIV update cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q   <= SEED;
         scroll_q <= '0;
         for (int i = 0; i < 4; i++) pos_q[i] <= PLAT_BASE + PLAT_GAP * 7'(i);
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         if ((statesig == 2'b11) && !freeze) begin
            if (scroll_q == DIV_LAST) begin
               scroll_q <= '0;
               for (int i = 0; i < 4; i++)
                  pos_q[i] <= (pos_q[i] == 7'd0) ? PLAT_WRAP : pos_q[i] - 7'd1;
            end else begin
               scroll_q <= scroll_q + 16'd1;
            end
         end
      end
   end

   // Shuffle next-state: draw candidates, pick the ball, then commit atomically.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      slot_d  = slot_q;
      fill_d  = fill_q;
      tries_d = tries_q;
      cand_d  = cand_q;
      commit  = 1'b0;
      draw    = lfsr_q[2:0];
      accept  = 1'b0;
      if (freeze) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (score_in != score_q) begin
                  score_d = score_in;
                  fill_d  = 3'd0;
                  tries_d = 8'd0;
                  state_d = GEN;
               end
            end
            GEN: begin
               // Black is the background colour and is never a legal draw.
               accept = (draw != 3'b000);
`ifdef DISTINCT_COLOURS_EN
               for (int k = 0; k < 4; k++)
                  if ((3'(k) < fill_q) && (slot_q[k] == draw)) accept = 1'b0;
`endif
               tries_d = tries_q + 8'd1;
               if (accept) begin
                  slot_d[fill_q[1:0]] = draw;
                  fill_d = fill_q + 3'd1;
               end
               if (fill_d == 3'd4) begin
                  state_d = PICK;
               end else if (tries_d == TRY_LIMIT) begin
                  for (int k = 0; k < 4; k++) begin
`ifdef DISTINCT_COLOURS_EN
                     // Replace the whole set so earlier draws cannot collide with the palette.
                     slot_d[k] = fallback_colour(k);
`else
                     if (3'(k) >= fill_d) slot_d[k] = fallback_colour(k);
`endif
                  end
                  state_d = PICK;
               end
            end
            PICK: begin
               cand_d  = slot_q[lfsr_q[1:0]];
               state_d = COMMIT;
            end
            COMMIT: begin
               if (statesig != 2'b11) begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Shuffle state and the published colour set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         score_q  <= '0;
         frozen_q <= 1'b0;
         fill_q   <= '0;
         tries_q  <= '0;
         cand_q   <= 3'b001;
         for (int k = 0; k < 4; k++) slot_q[k] <= 3'b000;
         col_q[0] <= 3'b001;
         col_q[1] <= 3'b010;
         col_q[2] <= 3'b100;
         col_q[3] <= 3'b110;
         ball_q   <= 3'b001;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         frozen_q <= freeze;
         fill_q   <= fill_d;
         tries_q  <= tries_d;
         cand_q   <= cand_d;
         slot_q   <= slot_d;
         if (commit) begin
            col_q  <= slot_q;
            ball_q <= cand_q;
         end
         busy_q <= (state_d != IDLE);
         done_q <= commit;
      end
   end

   assign position_plats = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
   assign color_plats    = {col_q[3], col_q[2], col_q[1], col_q[0]};
   assign color_ball     = ball_q;
   assign shuffle_busy   = busy_q;
   assign shuffle_done   = done_q;

endmodule

// File: tb/tb_platform_colour_gen.sv
// Directed bench for platform_colour_gen: reset, scroll, shuffle timing, commit hold,
// mid-shuffle reset, gameover freeze and a long run of score increments.
module tb_platform_colour_gen;

   localparam int MAX_TRIES = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  statesig = 2'b00;
   logic [31:0] score_in = 32'd0;
   logic        gameover = 1'b0;
   logic [27:0] position_plats;
   logic [11:0] color_plats;
   logic [2:0]  color_ball;
   logic        shuffle_busy;
   logic        shuffle_done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] m_lfsr;
   logic [31:0] score_v = 32'd0;

   localparam logic [27:0] POS_RST = {7'd95, 7'd70, 7'd45, 7'd20};
   localparam logic [11:0] COL_RST = 12'b110_100_010_001;

   platform_colour_gen dut (
      .clk            (clk),
      .resetn         (resetn),
      .statesig       (statesig),
      .score_in       (score_in),
      .gameover       (gameover),
      .position_plats (position_plats),
      .color_plats    (color_plats),
      .color_ball     (color_ball),
      .shuffle_busy   (shuffle_busy),
      .shuffle_done   (shuffle_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Reference LFSR, tracking the free-running generator cycle for cycle.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 16'hACE1;
      else         m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic logic [2:0] pal(input int k);
      logic [11:0] p;
      p = {3'b111, 3'b100, 3'b010, 3'b001};
      return p[k*3 +: 3];
   endfunction

   // Predict a shuffle from the LFSR value seen on the first GEN cycle.
   task automatic predict(input logic [15:0] l, output logic [11:0] cols,
                          output logic [2:0] ball, output int gen_cycles);
      logic [2:0] s [4];
      logic [2:0] d;
      bit ok;
      int fill, tries;
      fill = 0; tries = 0;
      for (int k = 0; k < 4; k++) s[k] = 3'b000;
      while (fill < 4 && tries < MAX_TRIES) begin
         d  = l[2:0];
         ok = (d != 3'b000);
`ifdef DISTINCT_COLOURS_EN
         for (int k = 0; k < fill; k++) if (s[k] == d) ok = 0;
`endif
         if (ok) begin s[fill] = d; fill++; end
         tries++;
         l = lfsr_step(l);
      end
      if (fill < 4)
         for (int k = 0; k < 4; k++) begin
`ifdef DISTINCT_COLOURS_EN
            s[k] = pal(k);
`else
            if (k >= fill) s[k] = pal(k);
`endif
         end
      ball = s[l[1:0]];
      cols = {s[3], s[2], s[1], s[0]};
      gen_cycles = tries;
   endtask

   // Drive a new score; returns at the first GEN cycle with the LFSR value it will draw from.
   task automatic start_shuffle(input logic [31:0] s, output logic [15:0] l);
      @(negedge clk);
      score_in = s;
      @(posedge clk);
      @(negedge clk);
      l = m_lfsr;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      resetn = 1'b0;
      gameover = 1'b0;
      statesig = 2'b00;
      score_in = 32'd0;
      score_v  = 32'd0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (position_plats !== POS_RST) begin n_fail++;
         $display("FAIL reset_pos got %h want %h", position_plats, POS_RST); end
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (position_plats !== POS_RST) begin n_fail++;
         $display("FAIL reset_pos_rel got %h want %h", position_plats, POS_RST); end
      n_checks++;
      if (color_plats !== COL_RST) begin n_fail++;
         $display("FAIL reset_col got %b want %b", color_plats, COL_RST); end
      n_checks++;
      if ({color_ball, shuffle_busy, shuffle_done} !== 5'b001_0_0) begin n_fail++;
         $display("FAIL reset_ball_flags got %b want 00100", {color_ball, shuffle_busy, shuffle_done}); end
   endtask

   task automatic test_scroll();
      statesig = 2'b11;
      for (int i = 1; i <= 168; i++) begin
         @(negedge clk);
         if (i == 7) begin
            n_checks++;
            if (position_plats[6:0] !== 7'd20) begin n_fail++;
               $display("FAIL scroll_7 got %0d want 20", position_plats[6:0]); end
         end
         if (i == 8) begin
            n_checks++;
            if (position_plats[6:0] !== 7'd19) begin n_fail++;
               $display("FAIL scroll_8 got %0d want 19", position_plats[6:0]); end
         end
         if (i == 160) begin
            n_checks++;
            if (position_plats !== {7'd75, 7'd50, 7'd25, 7'd0}) begin n_fail++;
               $display("FAIL scroll_160 got %h want %h", position_plats, {7'd75, 7'd50, 7'd25, 7'd0}); end
         end
      end
      n_checks++;
      if (position_plats !== {7'd74, 7'd49, 7'd24, 7'd116}) begin n_fail++;
         $display("FAIL scroll_wrap got %h want %h", position_plats, {7'd74, 7'd49, 7'd24, 7'd116}); end
      statesig = 2'b00;
   endtask

   task automatic test_shuffle();
      logic [15:0] l;
      logic [11:0] pc;
      logic [2:0]  pb;
      int g, cyc, busy_cnt;
      score_v = 32'd1;
      start_shuffle(score_v, l);
      predict(l, pc, pb, g);
      cyc = 1;
      busy_cnt = shuffle_busy ? 1 : 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (shuffle_done) break;
         if (shuffle_busy) busy_cnt++;
      end
      n_checks++;
      if (cyc !== g + 3) begin n_fail++;
         $display("FAIL shuffle_latency got %0d want %0d", cyc, g + 3); end
      n_checks++;
      if (busy_cnt !== g + 2) begin n_fail++;
         $display("FAIL shuffle_busy_len got %0d want %0d", busy_cnt, g + 2); end
      n_checks++;
      if (color_plats !== pc) begin n_fail++;
         $display("FAIL shuffle_cols got %b want %b", color_plats, pc); end
      n_checks++;
      if (color_ball !== pb) begin n_fail++;
         $display("FAIL shuffle_ball got %b want %b", color_ball, pb); end
      @(negedge clk);
      n_checks++;
      if ({shuffle_done, shuffle_busy} !== 2'b00) begin n_fail++;
         $display("FAIL shuffle_pulse_end got %b want 00", {shuffle_done, shuffle_busy}); end
   endtask

   task automatic test_commit_hold();
      logic [15:0] l;
      logic [11:0] pc, old_c;
      logic [2:0]  pb, old_b;
      int g;
      bit bad;
      old_c = color_plats;
      old_b = color_ball;
      score_v = score_v + 32'd1;
      start_shuffle(score_v, l);
      predict(l, pc, pb, g);
      repeat (3) @(negedge clk);
      statesig = 2'b11;
      bad = 0;
      for (int c = 5; c <= 20; c++) begin
         @(negedge clk);
         if (color_plats !== old_c || color_ball !== old_b || shuffle_done !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin n_fail++;
         $display("FAIL commit_hold got changed want held %b/%b", old_c, old_b); end
      statesig = 2'b00;
      @(negedge clk);
      n_checks++;
      if (shuffle_done !== 1'b1) begin n_fail++;
         $display("FAIL commit_release_done got %b want 1", shuffle_done); end
      n_checks++;
      if ({color_plats, color_ball} !== {pc, pb}) begin n_fail++;
         $display("FAIL commit_release_cols got %b want %b", {color_plats, color_ball}, {pc, pb}); end
   endtask

   task automatic test_reset_mid_shuffle();
      logic [15:0] l;
      score_v = score_v + 32'd1;
      start_shuffle(score_v, l);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if ({position_plats, color_plats, color_ball, shuffle_busy, shuffle_done} !==
          {POS_RST, COL_RST, 3'b001, 2'b00}) begin n_fail++;
         $display("FAIL mid_reset got %h/%b/%b/%b want %h/%b/001/00", position_plats, color_plats,
                  color_ball, {shuffle_busy, shuffle_done}, POS_RST, COL_RST); end
      score_in = 32'd0;
      score_v  = 32'd0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_gameover();
      logic [15:0] l;
      logic [27:0] p0;
      logic [11:0] c0;
      bit bad;
      p0 = position_plats;
      c0 = color_plats;
      score_v = score_v + 32'd1;
      start_shuffle(score_v, l);
      n_checks++;
      if (shuffle_busy !== 1'b1) begin n_fail++;
         $display("FAIL gameover_pre_busy got %b want 1", shuffle_busy); end
      gameover = 1'b1;
      @(negedge clk);
      n_checks++;
      if (shuffle_busy !== 1'b0) begin n_fail++;
         $display("FAIL gameover_busy got %b want 0", shuffle_busy); end
      statesig = 2'b11;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) score_in = score_v + 32'd7;
         @(negedge clk);
         if (position_plats !== p0 || color_plats !== c0 || shuffle_done !== 1'b0 ||
             shuffle_busy !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin n_fail++;
         $display("FAIL gameover_freeze got %h/%b want %h/%b", position_plats, color_plats, p0, c0); end
      reset_dut();
   endtask

   task automatic test_random_shuffles();
      logic [15:0] l;
      logic [11:0] pc;
      logic [2:0]  pb;
      logic [2:0]  c [4];
      int g, cyc, bad_lat, bad_col, bad_rule, dups;
      bad_lat = 0; bad_col = 0; bad_rule = 0; dups = 0;
      for (int i = 1; i <= 1000; i++) begin
         score_v = score_v + 32'd1;
         start_shuffle(score_v, l);
         predict(l, pc, pb, g);
         cyc = 1;
         while (cyc < 40 && !shuffle_done) begin
            @(negedge clk);
            cyc++;
         end
         if (cyc != g + 3) bad_lat++;
         if ({color_plats, color_ball} !== {pc, pb}) bad_col++;
         for (int k = 0; k < 4; k++) c[k] = color_plats[k*3 +: 3];
         if (c[0] == 3'b000 || c[1] == 3'b000 || c[2] == 3'b000 || c[3] == 3'b000) bad_rule++;
         if (color_ball != c[0] && color_ball != c[1] && color_ball != c[2] && color_ball != c[3])
            bad_rule++;
         if (c[0] == c[1] || c[0] == c[2] || c[0] == c[3] || c[1] == c[2] || c[1] == c[3] ||
             c[2] == c[3]) dups++;
      end
      n_checks++;
      if (bad_lat !== 0) begin n_fail++;
         $display("FAIL run_latency got %0d bad want 0", bad_lat); end
      n_checks++;
      if (bad_col !== 0) begin n_fail++;
         $display("FAIL run_colours got %0d bad want 0", bad_col); end
      n_checks++;
      if (bad_rule !== 0) begin n_fail++;
         $display("FAIL run_rules got %0d bad want 0", bad_rule); end
      n_checks++;
`ifdef DISTINCT_COLOURS_EN
      if (dups !== 0) begin n_fail++;
         $display("FAIL run_distinct got %0d duplicate sets want 0", dups); end
`else
      if (dups == 0) begin n_fail++;
         $display("FAIL run_duplicates got 0 duplicate sets want >0"); end
`endif
   endtask

   initial begin
      test_reset();
      test_scroll();
      test_shuffle();
      test_commit_hold();
      test_reset_mid_shuffle();
      test_gameover();
      test_random_shuffles();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
